lfsr5b_seq_ctrl: RTL and testbench
==================================

Name: lfsr5b_seq_ctrl

Overview:
Sequencer for the 5-bit LFSR datapath. It loads a seed on request and steps the LFSR a programmed number of times, presenting each state on a valid/ready output stream. It reports completion, abort and full-period wrap. It sits between a control master (start/seed/count) and a consumer of pseudo-random 5-bit words (test-pattern generator, scrambler).

Parameters:
CNT_W, 8, width of the step-count input and internal remaining-beats counter.

Ports:
clk  input  1  single system clock, all state on posedge
rst  input  1  asynchronous, active-high reset
start  input  1  request a new sequence; sampled only in IDLE
seed  input  5  initial LFSR state, captured with start
count  input  CNT_W  number of output beats to produce, captured with start
abort  input  1  terminate the running sequence
out_ready  input  1  consumer accepts out_data this cycle
out_valid  output  1  out_data holds a valid LFSR state
out_data  output  5  current LFSR state
busy  output  1  high in RUN and DONE
done  output  1  one-cycle pulse at end of sequence (normal or aborted)
wrap  output  1  sticky: LFSR returned to the captured seed during this sequence

Behaviour:
- Reset (async, rst=1): state=IDLE; lfsr=5'h1F; remaining=0; captured seed=5'h1F; out_valid=0, busy=0, done=0, wrap=0. Reset asserted mid-sequence aborts immediately with no done pulse.
- LFSR step (same taps as lfsr5b), q=lfsr[4:0]:
  - next[0]=q[4]
  - next[1]=q[0]
  - next[2]=q[1]^q[4]
  - next[3]=q[2]
  - next[4]=q[3]
  - Period is 31 for any nonzero state.
- Seed rule: seed==0 is replaced by 5'h1F at capture, because all-zero is the lock-up state.
- IDLE:
  - busy=0, out_valid=0.
  - start=1: capture seed (after zero fix) into lfsr and seed register; remaining=count; clear wrap.
  - If count==0, go to DONE; otherwise go to RUN.
  - Latency: start sampled at edge N gives out_valid=1 in the cycle after edge N.
- RUN:
  - out_valid=1, out_data=lfsr.
  - Beat accepted (out_valid & out_ready):
    - lfsr<=next(lfsr) and remaining<=remaining-1.
    - If next(lfsr)==seed register, set wrap.
    - If remaining==1, go to DONE.
  - Stall (out_ready=0): lfsr, out_data and remaining hold.
  - abort=1 in RUN: go to DONE at the next edge. Abort has priority over a simultaneous beat, so that beat is not counted and lfsr does not advance.
- DONE:
  - out_valid=0, busy=1, done=1 for exactly one cycle, then IDLE.
  - lfsr keeps its last value; out_data shows it while out_valid=0.
- start outside IDLE is ignored; it is not queued. abort outside RUN is ignored.
- wrap stays valid until the next accepted start or reset.
- count is unsigned. The maximum value 2^CNT_W-1 is legal; the LFSR simply cycles through multiple periods.

Test Plan:
1. Reset, then start with seed=5'h1F, count=4, out_ready=1 -> out_data 1F,1B,13,03 on consecutive cycles; done pulses once in the cycle after the 4th beat; wrap=0; final lfsr=5'h06.
2. start with seed=0, count=2 -> first beat 5'h1F (zero fix), then 5'h1B.
3. seed=5'h1F, count=31, out_ready=1 -> 31 beats with no repeats; wrap=1 after the 31st beat; done pulses.
4. seed=5'h1F, count=3, out_ready toggled 1,0,0,1,0,1 -> out_data holds during stalls; exactly 3 beats of 1F,1B,13; done after the 3rd beat.
5. count=0 start -> no out_valid; done pulses one cycle after start; busy=1 for that one cycle only.
6. count=10, assert abort together with out_ready on the 3rd beat -> only 2 beats counted, out_data stays 5'h13 (no step on abort cycle); done pulses next cycle. Then assert rst mid-RUN in a second run -> all outputs 0 and lfsr=5'h1F immediately, with no done pulse.

Source files
------------

// File: rtl/lfsr5b_seq_ctrl.sv
// ============================================================================
// Module   : lfsr5b_seq_ctrl
// Brief    : Seeds a 5-bit LFSR and streams a programmed number of its states
//            over a valid/ready output, with done/abort/wrap reporting.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module lfsr5b_seq_ctrl #(
   parameter int CNT_W = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [4:0]       seed,
   input  logic [CNT_W-1:0] count,
   input  logic             abort,
   input  logic             out_ready,
   output logic             out_valid,
   output logic [4:0]       out_data,
   output logic             busy,
   output logic             done,
   output logic             wrap
);

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_RUN  = 2'd1;
   localparam logic [1:0] S_DONE = 2'd2;

   logic [1:0]       state;
   logic [1:0]       state_nxt;
   logic [4:0]       lfsr;
   logic [4:0]       lfsr_step;
   logic [4:0]       seed_reg;
   logic [4:0]       seed_fix;
   logic [CNT_W-1:0] remaining;
   logic             wrap_reg;
   logic             accept;
   logic             beat;

   assign lfsr_step = {lfsr[3], lfsr[2], lfsr[1] ^ lfsr[4], lfsr[0], lfsr[4]};
   // All-zero is the lock-up state, so it is never loaded.
   assign seed_fix  = (seed == 5'd0) ? 5'h1F : seed;
   assign accept    = (state == S_IDLE) && start;
   // Abort wins over a simultaneous handshake: that beat is dropped.
   assign beat      = (state == S_RUN) && out_ready && !abort;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= S_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE: begin
            if (start) begin
               state_nxt = (count == '0) ? S_DONE : S_RUN;
            end
         end
         S_RUN: begin
            if (abort) begin
               state_nxt = S_DONE;
            end else if (beat && (remaining == CNT_W'(1))) begin
               state_nxt = S_DONE;
            end
         end
         S_DONE:  state_nxt = S_IDLE;
         default: state_nxt = S_IDLE;
      endcase
   end

   always_comb begin
      out_valid = (state == S_RUN);
      busy      = (state == S_RUN) || (state == S_DONE);
      done      = (state == S_DONE);
      out_data  = lfsr;
      wrap      = wrap_reg;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         lfsr      <= 5'h1F;
         seed_reg  <= 5'h1F;
         remaining <= '0;
         wrap_reg  <= 1'b0;
      end else if (accept) begin
         lfsr      <= seed_fix;
         seed_reg  <= seed_fix;
         remaining <= count;
         wrap_reg  <= 1'b0;
      end else if (beat) begin
         lfsr      <= lfsr_step;
         remaining <= remaining - CNT_W'(1);
         if (lfsr_step == seed_reg) begin
            wrap_reg <= 1'b1;
         end
      end
   end

endmodule

`default_nettype wire

// File: tb/tb_lfsr5b_seq_ctrl.sv
// ============================================================================
// Module   : tb_lfsr5b_seq_ctrl
// Brief    : Directed vector table plus hand sequences for lfsr5b_seq_ctrl.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_lfsr5b_seq_ctrl;

   logic       clk = 1'b0;
   logic       rst;
   logic       start;
   logic [4:0] seed;
   logic [7:0] count;
   logic       abort;
   logic       out_ready;
   logic       out_valid;
   logic [4:0] out_data;
   logic       busy;
   logic       done;
   logic       wrap;

   int n_checks = 0;
   int n_fail   = 0;

   typedef struct {
      logic       st;
      logic [4:0] sd;
      logic [7:0] cn;
      logic       ab;
      logic       rd;
      logic       ev;
      logic [4:0] ed;
      logic       eb;
      logic       edn;
      logic       ew;
   } vec_t;

   vec_t vecs[$];

   lfsr5b_seq_ctrl #(.CNT_W(8)) dut (
      .clk       (clk),
      .rst       (rst),
      .start     (start),
      .seed      (seed),
      .count     (count),
      .abort     (abort),
      .out_ready (out_ready),
      .out_valid (out_valid),
      .out_data  (out_data),
      .busy      (busy),
      .done      (done),
      .wrap      (wrap)
   );

   always #5 clk = ~clk;

   function automatic logic [4:0] lfsr_next(input logic [4:0] q);
      return {q[3], q[2], q[1] ^ q[4], q[0], q[4]};
   endfunction

   task automatic chk(input string name, input int got, input int exp);
      n_checks++;
      if (got != exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
      end
   endtask

   task automatic add(input logic st, input logic [4:0] sd, input logic [7:0] cn,
                      input logic ab, input logic rd, input logic ev,
                      input logic [4:0] ed, input logic eb, input logic edn,
                      input logic ew);
      vec_t v;
      v.st = st; v.sd = sd; v.cn = cn; v.ab = ab; v.rd = rd;
      v.ev = ev; v.ed = ed; v.eb = eb; v.edn = edn; v.ew = ew;
      vecs.push_back(v);
   endtask

   initial begin
      logic [4:0]  lf;
      logic [31:0] seen;

      //   st  seed   cnt  ab rd | valid data busy done wrap
      add(1, 5'h1F, 8'd4,  0, 1,   0, 5'h1F, 0, 0, 0);  // 4 beats from 1F
      add(0, 5'h00, 8'd0,  0, 1,   1, 5'h1F, 1, 0, 0);
      add(0, 5'h00, 8'd0,  0, 1,   1, 5'h1B, 1, 0, 0);
      add(0, 5'h00, 8'd0,  0, 1,   1, 5'h13, 1, 0, 0);
      add(0, 5'h00, 8'd0,  0, 1,   1, 5'h03, 1, 0, 0);
      add(0, 5'h00, 8'd0,  0, 1,   0, 5'h06, 1, 1, 0);
      add(0, 5'h00, 8'd0,  0, 1,   0, 5'h06, 0, 0, 0);
      add(1, 5'h00, 8'd2,  0, 1,   0, 5'h06, 0, 0, 0);  // zero seed fix
      add(0, 5'h00, 8'd0,  0, 1,   1, 5'h1F, 1, 0, 0);
      add(0, 5'h00, 8'd0,  0, 1,   1, 5'h1B, 1, 0, 0);
      add(0, 5'h00, 8'd0,  0, 1,   0, 5'h13, 1, 1, 0);
      add(0, 5'h00, 8'd0,  0, 1,   0, 5'h13, 0, 0, 0);
      add(1, 5'h1F, 8'd3,  0, 0,   0, 5'h13, 0, 0, 0);  // stalls 1,0,0,1,0,1
      add(0, 5'h00, 8'd0,  0, 1,   1, 5'h1F, 1, 0, 0);
      add(1, 5'h07, 8'd1,  0, 0,   1, 5'h1B, 1, 0, 0);  // start ignored in RUN
      add(0, 5'h00, 8'd0,  0, 0,   1, 5'h1B, 1, 0, 0);
      add(0, 5'h00, 8'd0,  0, 1,   1, 5'h1B, 1, 0, 0);
      add(0, 5'h00, 8'd0,  0, 0,   1, 5'h13, 1, 0, 0);
      add(0, 5'h00, 8'd0,  0, 1,   1, 5'h13, 1, 0, 0);
      add(1, 5'h07, 8'd0,  0, 1,   0, 5'h03, 1, 1, 0);  // start ignored in DONE
      add(0, 5'h00, 8'd0,  0, 1,   0, 5'h03, 0, 0, 0);
      add(1, 5'h05, 8'd0,  0, 1,   0, 5'h03, 0, 0, 0);  // count 0
      add(0, 5'h00, 8'd0,  0, 1,   0, 5'h05, 1, 1, 0);
      add(0, 5'h00, 8'd0,  0, 1,   0, 5'h05, 0, 0, 0);
      add(1, 5'h1F, 8'd10, 0, 1,   0, 5'h05, 0, 0, 0);  // abort on 3rd beat
      add(0, 5'h00, 8'd0,  0, 1,   1, 5'h1F, 1, 0, 0);
      add(0, 5'h00, 8'd0,  0, 1,   1, 5'h1B, 1, 0, 0);
      add(0, 5'h00, 8'd0,  1, 1,   1, 5'h13, 1, 0, 0);
      add(0, 5'h00, 8'd0,  1, 1,   0, 5'h13, 1, 1, 0);
      add(0, 5'h00, 8'd0,  1, 1,   0, 5'h13, 0, 0, 0);
      add(0, 5'h00, 8'd0,  0, 1,   0, 5'h13, 0, 0, 0);

      rst = 1'b1; start = 1'b0; seed = 5'h00; count = 8'd0;
      abort = 1'b0; out_ready = 1'b0;
      #1;
      chk("rst_valid", out_valid, 0);
      chk("rst_data",  out_data,  5'h1F);
      chk("rst_busy",  busy,      0);
      chk("rst_done",  done,      0);
      chk("rst_wrap",  wrap,      0);
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;

      foreach (vecs[i]) begin
         @(negedge clk);
         start = vecs[i].st; seed = vecs[i].sd; count = vecs[i].cn;
         abort = vecs[i].ab; out_ready = vecs[i].rd;
         chk($sformatf("v%0d_valid", i), out_valid, vecs[i].ev);
         chk($sformatf("v%0d_data",  i), out_data,  vecs[i].ed);
         chk($sformatf("v%0d_busy",  i), busy,      vecs[i].eb);
         chk($sformatf("v%0d_done",  i), done,      vecs[i].edn);
         chk($sformatf("v%0d_wrap",  i), wrap,      vecs[i].ew);
      end

      // Full period: 31 distinct states, wrap set by the last beat.
      @(negedge clk);
      start = 1'b1; seed = 5'h1F; count = 8'd31; abort = 1'b0; out_ready = 1'b1;
      @(negedge clk);
      start = 1'b0;
      lf = 5'h1F;
      seen = '0;
      for (int i = 0; i < 31; i++) begin
         chk($sformatf("p%0d_valid", i), out_valid, 1);
         chk($sformatf("p%0d_data",  i), out_data,  lf);
         chk($sformatf("p%0d_wrap",  i), wrap,      0);
         chk($sformatf("p%0d_norep", i), seen[out_data], 0);
         seen[out_data] = 1'b1;
         lf = lfsr_next(lf);
         @(negedge clk);
      end
      chk("p_end_valid", out_valid, 0);
      chk("p_end_done",  done,      1);
      chk("p_end_wrap",  wrap,      1);
      chk("p_end_data",  out_data,  5'h1F);
      @(negedge clk);
      chk("p_idle_done", done, 0);
      chk("p_idle_wrap", wrap, 1);

      // Reset in the middle of a run: immediate clear, no done pulse.
      start = 1'b1; seed = 5'h1F; count = 8'd10;
      @(negedge clk);
      start = 1'b0;
      chk("r_wrap_clr", wrap,      0);
      chk("r_valid",    out_valid, 1);
      chk("r_data0",    out_data,  5'h1F);
      @(negedge clk);
      chk("r_data1",    out_data,  5'h1B);
      #2 rst = 1'b1;
      #1;
      chk("r_async_valid", out_valid, 0);
      chk("r_async_busy",  busy,      0);
      chk("r_async_done",  done,      0);
      chk("r_async_wrap",  wrap,      0);
      chk("r_async_data",  out_data,  5'h1F);
      @(negedge clk);
      rst = 1'b0;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk($sformatf("r_post%0d_done",  i), done,      0);
         chk($sformatf("r_post%0d_busy",  i), busy,      0);
         chk($sformatf("r_post%0d_valid", i), out_valid, 0);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

`default_nettype wire
